// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the CPU/VGA SRAM arbiter.
package mem_arbiter_pkg;

  localparam int DEF_DATAWIDTH = 16;
  localparam int DEF_ADDRWIDTH = 14;

  typedef enum logic [1:0] {
    TAG_NONE   = 2'b00,
    TAG_CPU_RD = 2'b01,
    TAG_CPU_WR = 2'b10,
    TAG_VGA_RD = 2'b11
  } tag_t;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_VGA = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU, display and SRAM-side signals of the memory arbiter.
interface mem_arbiter_if #(
  parameter int DATAWIDTH = 16,
  parameter int ADDRWIDTH = 14
);
  logic                 cpu_req;
  logic                 cpu_we;
  logic [DATAWIDTH-1:0] cpu_addr;
  logic [DATAWIDTH-1:0] cpu_din;
  logic [DATAWIDTH-1:0] cpu_dout;
  logic                 cpu_ack;
  logic                 vga_req;
  logic [DATAWIDTH-1:0] vga_addr;
  logic [DATAWIDTH-1:0] vga_dout;
  logic                 vga_valid;
  logic                 sram_en;
  logic                 sram_we;
  logic [ADDRWIDTH-1:0] sram_addr;
  logic [DATAWIDTH-1:0] sram_din;
  logic [DATAWIDTH-1:0] sram_q;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_din, vga_req, vga_addr, sram_q,
    output cpu_dout, cpu_ack, vga_dout, vga_valid,
    output sram_en, sram_we, sram_addr, sram_din
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_din, vga_req, vga_addr, sram_q,
    input  cpu_dout, cpu_ack, vga_dout, vga_valid,
    input  sram_en, sram_we, sram_addr, sram_din
  );
endinterface

// File: rtl/mem_tag_pipe.sv
// READ_LAT-deep tag shift register; a tag entered at grant emerges when sram_q is valid.
// No backpressure: shifts every cycle, cleared asynchronously.
module mem_tag_pipe
  import mem_arbiter_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage [READ_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < READ_LAT; i++) stage[i] <= TAG_NONE;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < READ_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[READ_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin CPU/VGA arbiter onto one synchronous SRAM; ack/valid at grant+READ_LAT+1.
// Requesters hold req until completion; each has at most one access in flight.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int ADDRWIDTH = DEF_ADDRWIDTH,
  parameter int READ_LAT  = 1
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  logic                 cpu_busy, vga_busy;
  logic                 last_grant;
  logic                 cpu_ack_q, vga_valid_q;
  logic [DATAWIDTH-1:0] cpu_dout_q, vga_dout_q;

  logic                 gnt_vld, gnt_sel;
  logic                 sram_en, sram_we;
  logic [ADDRWIDTH-1:0] sram_addr;
  logic [DATAWIDTH-1:0] sram_din;
  tag_t                 tag_in, tag_out;

  logic cpu_elig, vga_elig;
  assign cpu_elig = bus.cpu_req && !cpu_busy;
  assign vga_elig = bus.vga_req && !vga_busy;

  // Outputs must read 0 while reset is held, so the grant is gated by rst.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_sel = GNT_CPU;
    if (rst) begin
      if (cpu_elig && vga_elig) begin
        gnt_vld = 1'b1;
        gnt_sel = (last_grant == GNT_CPU) ? GNT_VGA : GNT_CPU;
      end else if (cpu_elig) begin
        gnt_vld = 1'b1;
        gnt_sel = GNT_CPU;
      end else if (vga_elig) begin
        gnt_vld = 1'b1;
        gnt_sel = GNT_VGA;
      end
    end
  end

  always_comb begin
    sram_en   = 1'b0;
    sram_we   = 1'b0;
    sram_addr = '0;
    sram_din  = '0;
    tag_in    = TAG_NONE;
    if (gnt_vld) begin
      sram_en = 1'b1;
      if (gnt_sel == GNT_CPU) begin
        sram_we   = bus.cpu_we;
        sram_addr = bus.cpu_addr[ADDRWIDTH-1:0];
        sram_din  = bus.cpu_din;
        tag_in    = bus.cpu_we ? TAG_CPU_WR : TAG_CPU_RD;
      end else begin
        sram_addr = bus.vga_addr[ADDRWIDTH-1:0];
        tag_in    = TAG_VGA_RD;
      end
    end
  end

  mem_tag_pipe #(.READ_LAT(READ_LAT)) u_tags (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Busy spans grant through the ack cycle; it drops on the edge closing the ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_busy    <= 1'b0;
      vga_busy    <= 1'b0;
      last_grant  <= GNT_CPU;
      cpu_ack_q   <= 1'b0;
      vga_valid_q <= 1'b0;
      cpu_dout_q  <= '0;
      vga_dout_q  <= '0;
    end else begin
      if (gnt_vld && gnt_sel == GNT_CPU) cpu_busy <= 1'b1;
      else if (cpu_ack_q)                cpu_busy <= 1'b0;
      if (gnt_vld && gnt_sel == GNT_VGA) vga_busy <= 1'b1;
      else if (vga_valid_q)              vga_busy <= 1'b0;
      if (gnt_vld) last_grant <= gnt_sel;
      cpu_ack_q   <= (tag_out == TAG_CPU_RD) || (tag_out == TAG_CPU_WR);
      vga_valid_q <= (tag_out == TAG_VGA_RD);
      if (tag_out == TAG_CPU_RD) cpu_dout_q <= bus.sram_q;
      if (tag_out == TAG_VGA_RD) vga_dout_q <= bus.sram_q;
    end
  end

  logic unused_addr_hi;
  assign unused_addr_hi = ^{bus.cpu_addr[DATAWIDTH-1:ADDRWIDTH], bus.vga_addr[DATAWIDTH-1:ADDRWIDTH]};

  assign bus.sram_en   = sram_en;
  assign bus.sram_we   = sram_we;
  assign bus.sram_addr = sram_addr;
  assign bus.sram_din  = sram_din;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_dout  = cpu_dout_q;
  assign bus.vga_valid = vga_valid_q;
  assign bus.vga_dout  = vga_dout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: one instance at READ_LAT=1, one at READ_LAT=3.
module tb_mem_arbiter;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  exp_t cpu_q1[$];
  exp_t vga_q1[$];
  exp_t vga_q3[$];
  logic [15:0] exp_cpu_dout1 = 16'h0000;

  logic [15:0] mem1 [0:16383];
  logic [15:0] mem3 [0:16383];
  logic [15:0] q1 = '0;
  logic [15:0] d3_0 = '0, d3_1 = '0, d3_2 = '0;

  mem_arbiter_if #(.DATAWIDTH(16), .ADDRWIDTH(14)) bus1();
  mem_arbiter_if #(.DATAWIDTH(16), .ADDRWIDTH(14)) bus3();

  mem_arbiter #(.DATAWIDTH(16), .ADDRWIDTH(14), .READ_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mem_arbiter #(.DATAWIDTH(16), .ADDRWIDTH(14), .READ_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM models: read-before-write, data valid READ_LAT cycles after the address edge.
  always @(posedge clk) begin
    if (bus1.sram_en) begin
      q1 <= mem1[bus1.sram_addr];
      if (bus1.sram_we) mem1[bus1.sram_addr] <= bus1.sram_din;
    end
  end
  assign bus1.sram_q = q1;

  always @(posedge clk) begin
    if (bus3.sram_en) begin
      d3_0 <= mem3[bus3.sram_addr];
      if (bus3.sram_we) mem3[bus3.sram_addr] <= bus3.sram_din;
    end
    d3_1 <= d3_0;
    d3_2 <= d3_1;
  end
  assign bus3.sram_q = d3_2;

  function automatic exp_t mk(input logic [15:0] d, input int due);
    exp_t t;
    t.data = d;
    t.due  = due;
    return t;
  endfunction

  exp_t e_c1, e_v1, e_v3;
  always @(negedge clk) begin
    if (rst) begin
      if (bus1.cpu_ack) begin
        checks++;
        if (cpu_q1.size() == 0) begin
          errors++;
          $display("FAIL cpu_ack_unexpected cyc=%0d dout=%h", cyc, bus1.cpu_dout);
        end else begin
          e_c1 = cpu_q1.pop_front();
          if (bus1.cpu_dout !== e_c1.data || cyc != e_c1.due) begin
            errors++;
            $display("FAIL cpu_ack got dout=%h cyc=%0d want dout=%h cyc=%0d", bus1.cpu_dout, cyc, e_c1.data, e_c1.due);
          end
        end
      end
      if (bus1.vga_valid) begin
        checks++;
        if (vga_q1.size() == 0) begin
          errors++;
          $display("FAIL vga_valid_unexpected cyc=%0d dout=%h", cyc, bus1.vga_dout);
        end else begin
          e_v1 = vga_q1.pop_front();
          if (bus1.vga_dout !== e_v1.data || cyc != e_v1.due) begin
            errors++;
            $display("FAIL vga_valid got dout=%h cyc=%0d want dout=%h cyc=%0d", bus1.vga_dout, cyc, e_v1.data, e_v1.due);
          end
        end
      end
      if (bus3.vga_valid) begin
        checks++;
        if (vga_q3.size() == 0) begin
          errors++;
          $display("FAIL vga3_valid_unexpected cyc=%0d", cyc);
        end else begin
          e_v3 = vga_q3.pop_front();
          if (bus3.vga_dout !== e_v3.data || cyc != e_v3.due) begin
            errors++;
            $display("FAIL vga3_valid got dout=%h cyc=%0d want dout=%h cyc=%0d", bus3.vga_dout, cyc, e_v3.data, e_v3.due);
          end
        end
      end
      if (bus3.cpu_ack) begin
        checks++;
        errors++;
        $display("FAIL cpu3_ack_unexpected cyc=%0d", cyc);
      end
    end
  end

  // Waits for outstanding completions, releasing each request on its ack.
  task automatic drain1(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (bus1.cpu_ack)   bus1.cpu_req = 1'b0;
      if (bus1.vga_valid) bus1.vga_req = 1'b0;
      if (cpu_q1.size() == 0 && vga_q1.size() == 0) break;
    end
    checks++;
    if (cpu_q1.size() != 0 || vga_q1.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got pending cpu=%0d vga=%0d want 0 0", cpu_q1.size(), vga_q1.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus1.cpu_req = 1'b1; bus1.cpu_we = 1'b0; bus1.cpu_addr = 16'h0001; bus1.cpu_din = 16'h0000;
    bus1.vga_req = 1'b1; bus1.vga_addr = 16'h0002;
    bus3.cpu_req = 1'b0; bus3.cpu_we = 1'b0; bus3.cpu_addr = 16'h0000; bus3.cpu_din = 16'h0000;
    bus3.vga_req = 1'b1; bus3.vga_addr = 16'h0000;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus1.sram_en, bus1.sram_we, bus1.sram_addr, bus1.sram_din} !== 32'h0) begin
      errors++;
      $display("FAIL reset_sram got en=%b we=%b addr=%h din=%h want all 0", bus1.sram_en, bus1.sram_we, bus1.sram_addr, bus1.sram_din);
    end
    checks++;
    if ({bus1.cpu_ack, bus1.vga_valid, bus1.cpu_dout, bus1.vga_dout} !== 34'h0) begin
      errors++;
      $display("FAIL reset_resp got ack=%b valid=%b cdout=%h vdout=%h want all 0", bus1.cpu_ack, bus1.vga_valid, bus1.cpu_dout, bus1.vga_dout);
    end
    checks++;
    if ({bus3.sram_en, bus3.cpu_ack, bus3.vga_valid, bus3.vga_dout} !== 19'h0) begin
      errors++;
      $display("FAIL reset_dut3 got en=%b ack=%b valid=%b vdout=%h want all 0", bus3.sram_en, bus3.cpu_ack, bus3.vga_valid, bus3.vga_dout);
    end
    bus3.vga_req = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus1.sram_en, bus1.sram_we, bus1.sram_addr} !== {1'b1, 1'b0, 14'h0002}) begin
      errors++;
      $display("FAIL first_tie_vga got en=%b we=%b addr=%h want 1 0 0002", bus1.sram_en, bus1.sram_we, bus1.sram_addr);
    end
    vga_q1.push_back(mk(16'h2222, cyc + 2));
    @(negedge clk);
    checks++;
    if ({bus1.sram_en, bus1.sram_we, bus1.sram_addr} !== {1'b1, 1'b0, 14'h0001}) begin
      errors++;
      $display("FAIL second_grant_cpu got en=%b we=%b addr=%h want 1 0 0001", bus1.sram_en, bus1.sram_we, bus1.sram_addr);
    end
    cpu_q1.push_back(mk(16'h1111, cyc + 2));
    exp_cpu_dout1 = 16'h1111;
    drain1(10);
  endtask

  task automatic test_store_load();
    @(posedge clk); #1;
    bus1.cpu_req = 1'b1; bus1.cpu_we = 1'b1; bus1.cpu_addr = 16'h0010; bus1.cpu_din = 16'hBEEF;
    @(negedge clk);
    checks++;
    if ({bus1.sram_en, bus1.sram_we, bus1.sram_addr, bus1.sram_din} !== {1'b1, 1'b1, 14'h0010, 16'hBEEF}) begin
      errors++;
      $display("FAIL store_drive got en=%b we=%b addr=%h din=%h want 1 1 0010 beef", bus1.sram_en, bus1.sram_we, bus1.sram_addr, bus1.sram_din);
    end
    cpu_q1.push_back(mk(exp_cpu_dout1, cyc + 2));
    drain1(10);
    @(posedge clk); #1;
    bus1.cpu_req = 1'b1; bus1.cpu_we = 1'b0; bus1.cpu_din = 16'h0000;
    @(negedge clk);
    checks++;
    if ({bus1.sram_en, bus1.sram_we, bus1.sram_addr, bus1.sram_din} !== {1'b1, 1'b0, 14'h0010, 16'h0000}) begin
      errors++;
      $display("FAIL load_drive got en=%b we=%b addr=%h din=%h want 1 0 0010 0000", bus1.sram_en, bus1.sram_we, bus1.sram_addr, bus1.sram_din);
    end
    exp_cpu_dout1 = 16'hBEEF;
    cpu_q1.push_back(mk(16'hBEEF, cyc + 2));
    drain1(10);
  endtask

  task automatic test_contention();
    logic exp_vga;
    exp_vga = 1'b1;
    @(posedge clk); #1;
    bus1.cpu_req = 1'b1; bus1.cpu_we = 1'b0; bus1.cpu_addr = 16'h0020;
    bus1.vga_req = 1'b1; bus1.vga_addr = 16'h0030;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (bus1.sram_en !== ((k % 3) != 2)) begin
        errors++;
        $display("FAIL contention_en k=%0d got %b want %b", k, bus1.sram_en, (k % 3) != 2);
      end
      if (bus1.sram_en) begin
        checks++;
        if ((bus1.sram_addr == 14'h0030) !== exp_vga) begin
          errors++;
          $display("FAIL contention_order k=%0d got addr=%h want vga=%b", k, bus1.sram_addr, exp_vga);
        end
        if (bus1.sram_addr == 14'h0030) vga_q1.push_back(mk(16'h3030, cyc + 2));
        else                            cpu_q1.push_back(mk(16'h2020, cyc + 2));
        exp_vga = !exp_vga;
      end
      if (k == 11) begin
        bus1.cpu_req = 1'b0;
        bus1.vga_req = 1'b0;
      end
    end
    exp_cpu_dout1 = 16'h2020;
    drain1(10);
  endtask

  task automatic test_latency();
    int cg;
    @(posedge clk); #1;
    bus3.vga_req = 1'b1; bus3.vga_addr = 16'h0200;
    @(negedge clk);
    cg = cyc;
    checks++;
    if ({bus3.sram_en, bus3.sram_we, bus3.sram_addr} !== {1'b1, 1'b0, 14'h0200}) begin
      errors++;
      $display("FAIL lat3_grant got en=%b we=%b addr=%h want 1 0 0200", bus3.sram_en, bus3.sram_we, bus3.sram_addr);
    end
    vga_q3.push_back(mk(16'h1234, cg + 4));
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (bus3.sram_en !== 1'b0) begin
        errors++;
        $display("FAIL lat3_no_regrant cycle=G+%0d got en=%b want 0", k, bus3.sram_en);
      end
    end
    #1;
    bus3.vga_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus3.vga_dout !== 16'h1234 || bus3.vga_valid !== 1'b0 || vga_q3.size() != 0) begin
      errors++;
      $display("FAIL lat3_hold got dout=%h valid=%b pending=%0d want 1234 0 0", bus3.vga_dout, bus3.vga_valid, vga_q3.size());
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    bus1.cpu_req = 1'b1; bus1.cpu_we = 1'b0; bus1.cpu_addr = 16'h0010;
    @(negedge clk);
    checks++;
    if (bus1.sram_en !== 1'b1 || bus1.sram_addr !== 14'h0010) begin
      errors++;
      $display("FAIL rstmid_grant got en=%b addr=%h want 1 0010", bus1.sram_en, bus1.sram_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus1.cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus1.cpu_ack, bus1.cpu_dout, bus1.vga_dout, bus1.sram_en} !== 34'h0) begin
      errors++;
      $display("FAIL rstmid_clear got ack=%b cdout=%h vdout=%h en=%b want all 0", bus1.cpu_ack, bus1.cpu_dout, bus1.vga_dout, bus1.sram_en);
    end
    rst = 1'b1;
    exp_cpu_dout1 = 16'h0000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (bus1.cpu_ack !== 1'b0 || bus1.cpu_dout !== exp_cpu_dout1) begin
        errors++;
        $display("FAIL rstmid_no_ack k=%0d got ack=%b dout=%h want 0 0000", k, bus1.cpu_ack, bus1.cpu_dout);
      end
    end
  endtask

  task automatic test_trunc_hold();
    @(posedge clk); #1;
    bus1.cpu_req = 1'b1; bus1.cpu_we = 1'b0; bus1.cpu_addr = 16'hC005;
    @(negedge clk);
    checks++;
    if (bus1.sram_en !== 1'b1 || bus1.sram_addr !== 14'h0005) begin
      errors++;
      $display("FAIL trunc_addr got en=%b addr=%h want 1 0005", bus1.sram_en, bus1.sram_addr);
    end
    exp_cpu_dout1 = 16'hA5A5;
    cpu_q1.push_back(mk(16'hA5A5, cyc + 2));
    drain1(10);
    @(posedge clk); #1;
    bus1.cpu_req = 1'b1; bus1.cpu_we = 1'b1; bus1.cpu_addr = 16'h0040; bus1.cpu_din = 16'h5555;
    @(negedge clk);
    checks++;
    if ({bus1.sram_en, bus1.sram_we, bus1.sram_addr, bus1.sram_din} !== {1'b1, 1'b1, 14'h0040, 16'h5555}) begin
      errors++;
      $display("FAIL hold_store_drive got en=%b we=%b addr=%h din=%h want 1 1 0040 5555", bus1.sram_en, bus1.sram_we, bus1.sram_addr, bus1.sram_din);
    end
    cpu_q1.push_back(mk(exp_cpu_dout1, cyc + 2));
    drain1(10);
    @(negedge clk);
    checks++;
    if (bus1.cpu_dout !== 16'hA5A5) begin
      errors++;
      $display("FAIL hold_after_store got %h want a5a5", bus1.cpu_dout);
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem1[i] = 16'h0000;
      mem3[i] = 16'h0000;
    end
    mem1[14'h0001] = 16'h1111;
    mem1[14'h0002] = 16'h2222;
    mem1[14'h0005] = 16'hA5A5;
    mem1[14'h0020] = 16'h2020;
    mem1[14'h0030] = 16'h3030;
    mem3[14'h0200] = 16'h1234;
    test_reset();
    test_store_load();
    test_contention();
    test_latency();
    test_reset_mid();
    test_trunc_hold();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
